ula_8_bit: RTL and testbench
============================

// Module: ula_8_bit
// PURPOSE
//  8-bit 74181-style ALU: 16 logic functions (m=1) and 16 arithmetic functions (m=0) selected by s.
//  Produces carry-out, signed overflow, an equality flag and group carry-lookahead P/G.
//  All outputs are registered (1-cycle latency) for use as the execute stage of the datapath.
// PARAMETERS
//  none (fixed 8-bit width)
// PORTS
//  clk       in   1  clock; one clock domain, all state on rising edge
//  rst_n     in   1  reset, asynchronous, active-low
//  a         in   8  operand A
//  b         in   8  operand B
//  s         in   4  function select
//  m         in   1  1 = logic mode, 0 = arithmetic mode
//  c_in      in   1  carry-in, active-high (1 adds +1); ignored in logic mode
//  f         out  8  result
//  a_eq_b    out  1  1 when f == 8'hFF
//  c_out     out  1  carry-out of bit 7 (0 in logic mode)
//  overflow  out  1  two's-complement overflow (0 in logic mode)
//  p         out  1  group propagate, active-high (0 in logic mode)
//  g         out  1  group generate, active-high (0 in logic mode)
// BEHAVIOUR
//  - Combinational core; results captured on posedge clk, visible 1 cycle after inputs are sampled.
//  - rst_n=0 clears all outputs to 0 immediately, independent of clk; held until the first edge after release.
//  - No handshake, no FSM; new operation accepted every cycle.
//  - Logic (m=1), per bit: 0000 ~A | 0001 ~(A|B) | 0010 ~A&B | 0011 8'h00 | 0100 ~(A&B) | 0101 ~B
//    0110 A^B | 0111 A&~B | 1000 A&B | 1001 ~(A^B) | 1010 B | 1011 ~A|B | 1100 8'hFF
//    1101 A|~B | 1110 A|B | 1111 A.
//  - Arithmetic (m=0): {c_out,f} = X + Y + c_in, 9-bit sum, where X,Y are:
//    0000 A,0 | 0001 A|B,0 | 0010 A|~B,0 | 0011 0,FF | 0100 A,A&~B | 0101 A|B,A&~B
//    0110 A,~B (A-B-1+c_in) | 0111 A&~B,FF | 1000 A,A&B | 1001 A,B | 1010 A|~B,A&B
//    1011 A&B,FF | 1100 A,A | 1101 A|B,A | 1110 A|~B,A | 1111 A,FF.
//  - c_out = bit 8 of sum; for subtract (0110, c_in=1) c_out=1 means no borrow.
//  - overflow = (X[7]==Y[7]) & (f[7]!=X[7]).
//  - p = &(X^Y); g = carry out of bit 7 computed with carry-in forced to 0, using gi=Xi&Yi, pi=Xi^Yi.
//  - a_eq_b = &f in both modes (A==B detected via subtract-with-c_in=0 or XNOR).
//  - Undefined s/m values do not exist; all 32 combinations are defined above.
// TESTING
//  - m=0,s=1001,c_in=0: 05+03 -> f=08,c_out=0,ovf=0; 7F+01 -> f=80,ovf=1,c_out=0; FF+01 -> f=00,c_out=1,ovf=0.
//  - m=0,s=0110,c_in=1: 0A-05 -> f=05,c_out=1; 00-01 -> f=FF,c_out=0,a_eq_b=1; 80-01 -> f=7F,c_out=1,ovf=1.
//  - m=1,a=AA,b=55: s=1000 -> f=00; s=1110 -> f=FF; s=0110 -> f=FF; c_out=ovf=p=g=0.
//  - m=1,s=1001: a=b=55 -> f=FF,a_eq_b=1; a=55,b=AA -> f=00,a_eq_b=0.
//  - m=0,s=1001: a=0F,b=F0 -> p=1,g=0; a=FF,b=01 -> p=0,g=1.
//  - Assert rst_n=0 mid-stream between clock edges -> all outputs 0 at once; first result after release lags one edge.

Source files
------------

// File: rtl/ula_8_bit.sv
// 8-bit 74181-style ALU with registered result and flags.
// 16 logic functions (m=1), 16 arithmetic functions (m=0), carry/overflow/equality and group P/G.
module ula_8_bit (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [3:0] s,
    input  logic       m,
    input  logic       c_in,
    output logic [7:0] f,
    output logic       a_eq_b,
    output logic       c_out,
    output logic       overflow,
    output logic       p,
    output logic       g
);

    logic [7:0] w_x;
    logic [7:0] w_y;
    logic [8:0] w_sum;
    logic [8:0] w_gen_sum;
    logic [7:0] w_logic;
    logic [7:0] w_f;
    logic       w_c_out;
    logic       w_ovf;
    logic       w_p;
    logic       w_g;

    logic [7:0] r_f;
    logic       r_a_eq_b;
    logic       r_c_out;
    logic       r_ovf;
    logic       r_p;
    logic       r_g;

    // Adder operand selection for arithmetic mode.
    always_comb begin
        w_x = a;
        w_y = 8'h00;
        case (s)
            4'b0000: begin w_x = a;        w_y = 8'h00;    end
            4'b0001: begin w_x = a | b;    w_y = 8'h00;    end
            4'b0010: begin w_x = a | ~b;   w_y = 8'h00;    end
            4'b0011: begin w_x = 8'h00;    w_y = 8'hFF;    end
            4'b0100: begin w_x = a;        w_y = a & ~b;   end
            4'b0101: begin w_x = a | b;    w_y = a & ~b;   end
            4'b0110: begin w_x = a;        w_y = ~b;       end
            4'b0111: begin w_x = a & ~b;   w_y = 8'hFF;    end
            4'b1000: begin w_x = a;        w_y = a & b;    end
            4'b1001: begin w_x = a;        w_y = b;        end
            4'b1010: begin w_x = a | ~b;   w_y = a & b;    end
            4'b1011: begin w_x = a & b;    w_y = 8'hFF;    end
            4'b1100: begin w_x = a;        w_y = a;        end
            4'b1101: begin w_x = a | b;    w_y = a;        end
            4'b1110: begin w_x = a | ~b;   w_y = a;        end
            default: begin w_x = a;        w_y = 8'hFF;    end
        endcase
    end

    always_comb begin
        w_logic = 8'h00;
        case (s)
            4'b0000: w_logic = ~a;
            4'b0001: w_logic = ~(a | b);
            4'b0010: w_logic = ~a & b;
            4'b0011: w_logic = 8'h00;
            4'b0100: w_logic = ~(a & b);
            4'b0101: w_logic = ~b;
            4'b0110: w_logic = a ^ b;
            4'b0111: w_logic = a & ~b;
            4'b1000: w_logic = a & b;
            4'b1001: w_logic = ~(a ^ b);
            4'b1010: w_logic = b;
            4'b1011: w_logic = ~a | b;
            4'b1100: w_logic = 8'hFF;
            4'b1101: w_logic = a | ~b;
            4'b1110: w_logic = a | b;
            default: w_logic = a;
        endcase
    end

    assign w_sum     = {1'b0, w_x} + {1'b0, w_y} + {8'h00, c_in};
    // Group generate is the carry out with carry-in forced low.
    assign w_gen_sum = {1'b0, w_x} + {1'b0, w_y};

    assign w_f     = m ? w_logic : w_sum[7:0];
    assign w_c_out = ~m & w_sum[8];
    assign w_ovf   = ~m & (w_x[7] == w_y[7]) & (w_sum[7] != w_x[7]);
    assign w_p     = ~m & (&(w_x ^ w_y));
    assign w_g     = ~m & w_gen_sum[8];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_f      <= 8'h00;
            r_a_eq_b <= 1'b0;
            r_c_out  <= 1'b0;
            r_ovf    <= 1'b0;
            r_p      <= 1'b0;
            r_g      <= 1'b0;
        end else begin
            r_f      <= w_f;
            r_a_eq_b <= &w_f;
            r_c_out  <= w_c_out;
            r_ovf    <= w_ovf;
            r_p      <= w_p;
            r_g      <= w_g;
        end
    end

    assign f        = r_f;
    assign a_eq_b   = r_a_eq_b;
    assign c_out    = r_c_out;
    assign overflow = r_ovf;
    assign p        = r_p;
    assign g        = r_g;

endmodule

// File: tb/tb_ula_8_bit.sv
// Bench for ula_8_bit: directed vectors, randomized operations against a reference model,
// and asynchronous reset behaviour.
module tb_ula_8_bit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] a = 8'h00;
    logic [7:0] b = 8'h00;
    logic [3:0] s = 4'h0;
    logic       m = 1'b0;
    logic       c_in = 1'b0;
    logic [7:0] f;
    logic       a_eq_b;
    logic       c_out;
    logic       overflow;
    logic       p;
    logic       g;

    int n_checks = 0;
    int n_pass   = 0;

    ula_8_bit dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .a        (a),
        .b        (b),
        .s        (s),
        .m        (m),
        .c_in     (c_in),
        .f        (f),
        .a_eq_b   (a_eq_b),
        .c_out    (c_out),
        .overflow (overflow),
        .p        (p),
        .g        (g)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    endtask

    // Reference: returns {f, a_eq_b, c_out, overflow, p, g}.
    function automatic logic [12:0] model(input logic [7:0] ma, input logic [7:0] mb,
                                          input logic [3:0] ms, input logic mm, input logic mc);
        logic [7:0] x, y, rf, res;
        logic [3:0] tt;
        int sum, ssum, raw;
        logic co, ov, pp, gg;
        if (mm) begin
            // Each logic function as a truth table indexed by {a_bit, b_bit}.
            case (ms)
                4'h0: tt = 4'b0011;  4'h1: tt = 4'b0001;  4'h2: tt = 4'b0010;  4'h3: tt = 4'b0000;
                4'h4: tt = 4'b0111;  4'h5: tt = 4'b0101;  4'h6: tt = 4'b0110;  4'h7: tt = 4'b0100;
                4'h8: tt = 4'b1000;  4'h9: tt = 4'b1001;  4'hA: tt = 4'b1010;  4'hB: tt = 4'b1011;
                4'hC: tt = 4'b1111;  4'hD: tt = 4'b1101;  4'hE: tt = 4'b1110;  default: tt = 4'b1100;
            endcase
            for (int i = 0; i < 8; i++) rf[i] = tt[{ma[i], mb[i]}];
            return {rf, (rf == 8'hFF), 4'b0000};
        end
        case (ms)
            4'h0: begin x = ma;        y = 8'h00;    end
            4'h1: begin x = ma | mb;   y = 8'h00;    end
            4'h2: begin x = ma | ~mb;  y = 8'h00;    end
            4'h3: begin x = 8'h00;     y = 8'hFF;    end
            4'h4: begin x = ma;        y = ma & ~mb; end
            4'h5: begin x = ma | mb;   y = ma & ~mb; end
            4'h6: begin x = ma;        y = ~mb;      end
            4'h7: begin x = ma & ~mb;  y = 8'hFF;    end
            4'h8: begin x = ma;        y = ma & mb;  end
            4'h9: begin x = ma;        y = mb;       end
            4'hA: begin x = ma | ~mb;  y = ma & mb;  end
            4'hB: begin x = ma & mb;   y = 8'hFF;    end
            4'hC: begin x = ma;        y = ma;       end
            4'hD: begin x = ma | mb;   y = ma;       end
            4'hE: begin x = ma | ~mb;  y = ma;       end
            default: begin x = ma;     y = 8'hFF;    end
        endcase
        raw  = int'(x) + int'(y);
        sum  = raw + int'(mc);
        ssum = int'($signed(x)) + int'($signed(y)) + int'(mc);
        res  = sum[7:0];
        co   = (sum > 255);
        ov   = (ssum > 127) || (ssum < -128);
        pp   = (raw == 255);
        gg   = (raw > 255);
        return {res, (res == 8'hFF), co, ov, pp, gg};
    endfunction

    // Drive inputs away from the edge, capture on the next posedge, settle 1 time unit.
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb, input logic [3:0] ts,
                          input logic tm, input logic tc);
        a = ta; b = tb; s = ts; m = tc ? tm : tm; c_in = tc;
        @(posedge clk);
        #1;
        $display("op m=%0d s=%b c_in=%0d a=%h b=%h -> f=%h eq=%0d co=%0d ov=%0d p=%0d g=%0d",
                 tm, ts, tc, ta, tb, f, a_eq_b, c_out, overflow, p, g);
    endtask

    function automatic logic [12:0] outs();
        return {f, a_eq_b, c_out, overflow, p, g};
    endfunction

    initial begin
        logic [7:0] ra, rb;
        logic [3:0] rs;
        logic       rm, rc;
        logic [12:0] exp_v;

        #1;
        check("reset_state", {3'b0, outs()}, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Arithmetic add
        run_op(8'h05, 8'h03, 4'b1001, 1'b0, 1'b0);
        check("add05_03_f", {8'h0, f}, 16'h0008);
        check("add05_03_flags", {12'h0, c_out, overflow, a_eq_b, 1'b0}, 16'h0000);
        run_op(8'h7F, 8'h01, 4'b1001, 1'b0, 1'b0);
        check("add7F_01_f", {8'h0, f}, 16'h0080);
        check("add7F_01_ovf_co", {14'h0, overflow, c_out}, 16'h0002);
        run_op(8'hFF, 8'h01, 4'b1001, 1'b0, 1'b0);
        check("addFF_01_f", {8'h0, f}, 16'h0000);
        check("addFF_01_co_ovf", {14'h0, c_out, overflow}, 16'h0002);

        // Subtract
        run_op(8'h0A, 8'h05, 4'b0110, 1'b0, 1'b1);
        check("sub0A_05", {7'h0, f, c_out}, {7'h0, 8'h05, 1'b1});
        run_op(8'h00, 8'h01, 4'b0110, 1'b0, 1'b1);
        check("sub00_01", {6'h0, f, c_out, a_eq_b}, {6'h0, 8'hFF, 1'b0, 1'b1});
        run_op(8'h80, 8'h01, 4'b0110, 1'b0, 1'b1);
        check("sub80_01", {6'h0, f, c_out, overflow}, {6'h0, 8'h7F, 1'b1, 1'b1});

        // Logic mode
        run_op(8'hAA, 8'h55, 4'b1000, 1'b1, 1'b1);
        check("and_AA_55", {8'h0, f}, 16'h0000);
        check("logic_flags", {12'h0, c_out, overflow, p, g}, 16'h0000);
        run_op(8'hAA, 8'h55, 4'b1110, 1'b1, 1'b0);
        check("or_AA_55", {8'h0, f}, 16'h00FF);
        run_op(8'hAA, 8'h55, 4'b0110, 1'b1, 1'b1);
        check("xor_AA_55", {8'h0, f}, 16'h00FF);
        check("xor_flags", {12'h0, c_out, overflow, p, g}, 16'h0000);
        run_op(8'h55, 8'h55, 4'b1001, 1'b1, 1'b0);
        check("xnor_eq", {7'h0, f, a_eq_b}, {7'h0, 8'hFF, 1'b1});
        run_op(8'h55, 8'hAA, 4'b1001, 1'b1, 1'b0);
        check("xnor_ne", {7'h0, f, a_eq_b}, {7'h0, 8'h00, 1'b0});

        // Group propagate / generate
        run_op(8'h0F, 8'hF0, 4'b1001, 1'b0, 1'b0);
        check("pg_0F_F0", {14'h0, p, g}, 16'h0002);
        run_op(8'hFF, 8'h01, 4'b1001, 1'b0, 1'b0);
        check("pg_FF_01", {14'h0, p, g}, 16'h0001);

        // Randomized operations against the model
        for (int i = 0; i < 300; i++) begin
            ra = 8'($urandom); rb = 8'($urandom);
            rs = 4'($urandom); rm = 1'($urandom); rc = 1'($urandom);
            if (i % 10 == 0) rb = ra;
            exp_v = model(ra, rb, rs, rm, rc);
            run_op(ra, rb, rs, rm, rc);
            check($sformatf("rand%0d_m%0d_s%h", i, rm, rs), {3'b0, outs()}, {3'b0, exp_v});
        end

        // Asynchronous reset mid-stream
        run_op(8'hFF, 8'h01, 4'b1001, 1'b0, 1'b0);
        check("pre_reset", {3'b0, outs()}, {3'b0, model(8'hFF, 8'h01, 4'b1001, 1'b0, 1'b0)});
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_now", {3'b0, outs()}, 16'h0000);
        @(posedge clk);
        #1;
        check("reset_held", {3'b0, outs()}, 16'h0000);
        a = 8'h05; b = 8'h03; s = 4'b1001; m = 1'b0; c_in = 1'b0;
        #2;
        rst_n = 1'b1;
        #1;
        check("release_no_edge", {3'b0, outs()}, 16'h0000);
        @(posedge clk);
        #1;
        check("first_after_release", {3'b0, outs()}, {3'b0, model(8'h05, 8'h03, 4'b1001, 1'b0, 1'b0)});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
